// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline hazard/sequencing controller
//
// Contents:
//   pc_state_t  - controller states (RUN, DRAIN, HALTED)
//   WB_SEL_MEM  - writeback-select code of a load (result comes from memory)
//   pipe_ctl_t  - bundle of PC/pipeline-register enables and flushes
//   CTL_*       - the fixed enable/flush patterns the controller drives

package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } pc_state_t;

    localparam logic [1:0] WB_SEL_MEM = 2'b01;

    typedef struct packed {
        logic en_pc;
        logic en_ifid;
        logic en_idex;
        logic en_exmem;
        logic en_memwb;
        logic flush_ifid;
        logic flush_idex;
        logic flush_exmem;
        logic flush_memwb;
    } pipe_ctl_t;

    // Free-running pipeline.
    localparam pipe_ctl_t CTL_RUN = '{
        en_pc: 1'b1, en_ifid: 1'b1, en_idex: 1'b1, en_exmem: 1'b1, en_memwb: 1'b1,
        flush_ifid: 1'b0, flush_idex: 1'b0, flush_exmem: 1'b0, flush_memwb: 1'b0
    };

    // Everything frozen: memory wait or halted core.
    localparam pipe_ctl_t CTL_FREEZE = '{
        en_pc: 1'b0, en_ifid: 1'b0, en_idex: 1'b0, en_exmem: 1'b0, en_memwb: 1'b0,
        flush_ifid: 1'b0, flush_idex: 1'b0, flush_exmem: 1'b0, flush_memwb: 1'b0
    };

    // Reset: PC held, every pipeline register loads a bubble.
    localparam pipe_ctl_t CTL_RESET = '{
        en_pc: 1'b0, en_ifid: 1'b1, en_idex: 1'b1, en_exmem: 1'b1, en_memwb: 1'b1,
        flush_ifid: 1'b1, flush_idex: 1'b1, flush_exmem: 1'b1, flush_memwb: 1'b1
    };

    // Halt detect and drain: stop fetching, kill the younger stages,
    // let the older stages retire.
    localparam pipe_ctl_t CTL_DRAIN = '{
        en_pc: 1'b0, en_ifid: 1'b1, en_idex: 1'b1, en_exmem: 1'b1, en_memwb: 1'b1,
        flush_ifid: 1'b1, flush_idex: 1'b1, flush_exmem: 1'b0, flush_memwb: 1'b0
    };

    // Taken jump: PC loads the target, the two wrong-path instructions die.
    localparam pipe_ctl_t CTL_JUMP = '{
        en_pc: 1'b1, en_ifid: 1'b1, en_idex: 1'b1, en_exmem: 1'b1, en_memwb: 1'b1,
        flush_ifid: 1'b1, flush_idex: 1'b1, flush_exmem: 1'b0, flush_memwb: 1'b0
    };

    // Load-use: hold PC and IF/ID, insert one bubble into EX.
    localparam pipe_ctl_t CTL_STALL = '{
        en_pc: 1'b0, en_ifid: 1'b0, en_idex: 1'b1, en_exmem: 1'b1, en_memwb: 1'b1,
        flush_ifid: 1'b0, flush_idex: 1'b1, flush_exmem: 1'b0, flush_memwb: 1'b0
    };

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - W-bit event counter that sticks at all-ones
//
// Ports:
//   clk   in      clock
//   reset in      synchronous active-high clear
//   inc   in      count one event this cycle
//   q     out [W] current count

module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - hazard, jump-flush, halt-drain and memory-wait sequencing for the 5-stage pipeline
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   rs_id, rt_id [3]                ID source registers
//   uses_rs_id, uses_rt_id          ID instruction reads that source
//   regwrite_adr_ex [3]             EX destination register
//   regwrite_ex                     EX instruction writes a register
//   regwrite_dat_controll_ex [2]    EX writeback source select
//   jump                            taken jump resolved in EX
//   is_halt_ex                      halt instruction in EX
//   mem_wait                        main memory busy, freeze everything
//   en_pc, en_ifid .. en_memwb      PC / pipeline register enables (combinational)
//   flush_ifid .. flush_memwb       load bubble when enabled (combinational)
//   flushed                         registered, fetch refilling after a jump flush
//   is_halt                         registered, core halted
//   stall_count, flush_count [CNT_W] saturating debug counters

module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       rs_id,
    input  logic [2:0]       rt_id,
    input  logic             uses_rs_id,
    input  logic             uses_rt_id,
    input  logic [2:0]       regwrite_adr_ex,
    input  logic             regwrite_ex,
    input  logic [1:0]       regwrite_dat_controll_ex,
    input  logic             jump,
    input  logic             is_halt_ex,
    input  logic             mem_wait,
    output logic             en_pc,
    output logic             en_ifid,
    output logic             en_idex,
    output logic             en_exmem,
    output logic             en_memwb,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             flush_exmem,
    output logic             flush_memwb,
    output logic             flushed,
    output logic             is_halt,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int DCNT_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DCNT_W-1:0] DCNT_LOAD = DCNT_W'(DRAIN_CYCLES);
    localparam logic [DCNT_W-1:0] DCNT_ONE  = DCNT_W'(1);

    pc_state_t         state_d, state_q;
    logic [DCNT_W-1:0] dcnt_d, dcnt_q;
    logic              flushed_d, flushed_q;
    logic              is_halt_d, is_halt_q;

    pipe_ctl_t ctl;
    logic      lu;
    logic      inc_stall;
    logic      inc_flush;

    // A load in EX produces its data only after MEM, so a dependent
    // instruction in ID must wait one cycle. r0 is an ordinary register here.
    assign lu = regwrite_ex
             && (regwrite_dat_controll_ex == WB_SEL_MEM)
             && ((uses_rs_id && (rs_id == regwrite_adr_ex))
              || (uses_rt_id && (rt_id == regwrite_adr_ex)));

    always_comb begin
        state_d   = state_q;
        dcnt_d    = dcnt_q;
        flushed_d = 1'b0;
        ctl       = CTL_FREEZE;
        inc_stall = 1'b0;
        inc_flush = 1'b0;

        if (reset) begin
            ctl = CTL_RESET;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (mem_wait) begin
                        ctl = CTL_FREEZE;
                    end else if (is_halt_ex) begin
                        ctl     = CTL_DRAIN;
                        state_d = DRAIN;
                        dcnt_d  = DCNT_LOAD;
                    end else if (jump) begin
                        ctl       = CTL_JUMP;
                        inc_flush = 1'b1;
                        flushed_d = 1'b1;
                    end else if (lu) begin
                        ctl       = CTL_STALL;
                        inc_stall = 1'b1;
                    end else begin
                        ctl = CTL_RUN;
                    end
                end

                DRAIN: begin
                    // jump and lu belong to killed instructions; ignore them.
                    if (mem_wait) begin
                        ctl = CTL_FREEZE;
                    end else begin
                        ctl    = CTL_DRAIN;
                        dcnt_d = dcnt_q - DCNT_ONE;
                        if (dcnt_q == DCNT_ONE) begin
                            state_d = HALTED;
                        end
                    end
                end

                HALTED: begin
                    ctl = CTL_FREEZE;
                end

                default: begin
                    ctl     = CTL_FREEZE;
                    state_d = RUN;
                end
            endcase
        end

        // is_halt rises on the same edge the state enters HALTED.
        is_halt_d = (state_d == HALTED);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RUN;
            dcnt_q    <= '0;
            flushed_q <= 1'b0;
            is_halt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dcnt_q    <= dcnt_d;
            flushed_q <= flushed_d;
            is_halt_q <= is_halt_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (inc_stall),
        .q     (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (inc_flush),
        .q     (flush_count)
    );

    assign en_pc       = ctl.en_pc;
    assign en_ifid     = ctl.en_ifid;
    assign en_idex     = ctl.en_idex;
    assign en_exmem    = ctl.en_exmem;
    assign en_memwb    = ctl.en_memwb;
    assign flush_ifid  = ctl.flush_ifid;
    assign flush_idex  = ctl.flush_idex;
    assign flush_exmem = ctl.flush_exmem;
    assign flush_memwb = ctl.flush_memwb;
    assign flushed     = flushed_q;
    assign is_halt     = is_halt_q;

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Hazard and sequencing controller for the 5-stage 16-bit pipeline (IF/ID/EX/MEM/WB). It drives the PC enable and the per-register `en_*`/`flush_*` pairs from four conditions: load-use hazards, taken jumps from EX, halt, and main-memory wait. It owns the halt drain sequence and the registered `is_halt` output. Two saturating counters record stall and flush events for debug.

## Interface
Parameters:
- `DRAIN_CYCLES`, default 2: cycles spent retiring EX/MEM and MEM/WB contents after a halt is detected.
- `CNT_W`, default 16: width of the event counters.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `rs_id`, `rt_id` in 3 each: source register addresses of the instruction in ID.
- `uses_rs_id`, `uses_rt_id` in 1 each: the ID instruction reads that source.
- `regwrite_adr_ex` in 3: destination register of the instruction in EX.
- `regwrite_ex` in 1: the EX instruction writes a register.
- `regwrite_dat_controll_ex` in 2: writeback source select of the EX instruction.
- `jump` in 1: taken branch/jump resolved in EX.
- `is_halt_ex` in 1: a halt instruction is in EX.
- `mem_wait` in 1: main memory is not ready; freeze the whole pipeline.
- `en_pc` out 1: PC register enable.
- `en_ifid`, `en_idex`, `en_exmem`, `en_memwb` out 1 each: pipeline register enables.
- `flush_ifid`, `flush_idex`, `flush_exmem`, `flush_memwb` out 1 each: a register loads a bubble at the next edge when both its `en_*` and `flush_*` are 1.
- `flushed` out 1: registered; the fetch stage is refilling after a jump flush.
- `is_halt` out 1: registered; the core has halted.
- `stall_count` out CNT_W: load-use stall cycles, saturating.
- `flush_count` out CNT_W: jump flushes, saturating.

## Operation
- State machine states: RUN, DRAIN, HALTED. The drain counter `dcnt` is $clog2(DRAIN_CYCLES+1) bits wide.
- Load-use hazard (`lu`) is true when all of the following hold:
  - `regwrite_ex` is 1;
  - `regwrite_dat_controll_ex == WB_SEL_MEM`;
  - (`uses_rs_id` and `rs_id == regwrite_adr_ex`) or (`uses_rt_id` and `rt_id == regwrite_adr_ex`).
- Register 0 is not special; a match on r0 still stalls.
- Event priority in RUN: `mem_wait` > `is_halt_ex` > `jump` > `lu` > normal.
- RUN outputs by event:
  - Normal: all `en_*` = 1, all `flush_*` = 0.
  - `mem_wait`: all `en_*` = 0 (including `en_pc`), all `flush_*` = 0. No state change, no counter update.
  - `is_halt_ex`: `en_pc` = 0; `flush_ifid` = `flush_idex` = 1; EX/MEM and MEM/WB enabled. Next state is DRAIN with `dcnt` = DRAIN_CYCLES.
  - `jump`: `en_pc` = 1 (loads target); `flush_ifid` = `flush_idex` = 1; `flush_count` increments.
  - `lu`: `en_pc` = `en_ifid` = 0; `flush_idex` = 1 (bubble into EX); EX/MEM and MEM/WB enabled; `stall_count` increments.
- DRAIN:
  - Outputs: `en_pc` = 0; IF/ID and ID/EX enabled with flush = 1; EX/MEM and MEM/WB enabled with no flush.
  - `mem_wait` freezes all `en_*`, and `dcnt` holds.
  - Otherwise `dcnt` decrements. At `dcnt == 1`, next state is HALTED.
  - `jump` and `lu` are ignored.
- HALTED: all `en_*` = 0, all `flush_*` = 0, `is_halt` = 1. The only exit is `reset`.
- `flushed` is 1 in the cycle after an accepted jump flush, otherwise 0.
- Counters saturate at all-ones and never wrap.

## Timing
- `en_*`/`flush_*` are combinational (Mealy) from state and inputs, with zero latency.
- `flushed`, `is_halt`, the counters, state and `dcnt` are registered and update at the rising edge.
- Reset behaviour:
  - While `reset` = 1: `en_pc` = 0; all pipeline `en_*` = 1 and all `flush_*` = 1, so the pipeline registers clear.
  - At the edge with `reset` = 1: state = RUN, `dcnt` = 0, `flushed` = 0, `is_halt` = 0, `stall_count` = `flush_count` = 0.
  - Reset mid-DRAIN or in HALTED returns to RUN on the next edge.
- Load-use stall lasts exactly 1 cycle; the next cycle the load is in MEM and `lu` drops.
- Jump penalty is 2 bubbles.
- Halt latency: `is_halt` rises DRAIN_CYCLES+1 edges after the first cycle `is_halt_ex` = 1, plus any `mem_wait` cycles.

## Structure
- `pipe_ctrl_pkg` holds:
  - `typedef enum logic [1:0] {RUN, DRAIN, HALTED} pc_state_t`;
  - `localparam logic [1:0] WB_SEL_MEM = 2'b01`;
  - the pipeline-enable bundle struct.
- Sub-module `sat_counter` (parameter W; ports clk, reset, inc, q) is instantiated twice.
- Hazard compare stays inline.

## Test plan
- Load-use:
  - Stimulus: `regwrite_ex` = 1, `regwrite_dat_controll_ex` = 2'b01, `regwrite_adr_ex` = 3, `rs_id` = 3, `uses_rs_id` = 1.
  - Expected: `en_pc` = `en_ifid` = 0 and `flush_idex` = 1 for one cycle; `stall_count` reads 1.
- Jump:
  - Stimulus: `jump` = 1 for 1 cycle.
  - Expected: `flush_ifid` = `flush_idex` = 1 and `en_pc` = 1 that cycle; `flushed` = 1 the next cycle; `flush_count` reads 1.
- Halt with `lu` and `jump` also asserted:
  - Stimulus: `is_halt_ex` = 1 while `lu` and `jump` are both asserted.
  - Expected: halt wins, `flush_count` and `stall_count` stay 0. With DRAIN_CYCLES = 2, `is_halt` = 1 at the 3rd edge, and all `en_*` = 0 thereafter.
- `mem_wait` during DRAIN:
  - Stimulus: `mem_wait` = 1 for 4 cycles in DRAIN.
  - Expected: all `en_*` = 0, and `is_halt` is delayed by exactly 4 cycles.
- Reset:
  - Stimulus: `reset` in DRAIN, then again in HALTED.
  - Expected: after each, the next cycle is RUN with `is_halt` = 0, counters = 0 and `flushed` = 0.
- Saturation:
  - Stimulus: CNT_W = 2, 5 load-use stalls.
  - Expected: `stall_count` = 3.
